// File: rtl/multicycle_ctrl_if.sv
// Memory request/acknowledge port between the control FSM and the memory system.
interface multicycle_ctrl_if;
  logic       mem_req;
  logic       mem_we;
  logic [1:0] addr_sel;
  logic       mem_ack;

  // Controller side: issues requests, receives the completion strobe
  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ack
  );

  // Memory side: serves requests and raises mem_ack when done
  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 32-bit CPU datapath.
// Sequences fetch, decode, execute, memory and write-back, and traps on
// illegal encodings or a memory watchdog timeout. Outputs are decoded
// combinationally from the current state, opcode and live ack/flags.
module multicycle_ctrl #(
  parameter int unsigned MEM_TO = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [5:0]              opcode,
  input  logic [1:0]              mode,
  input  logic                    flag_z,
  input  logic                    flag_n,
  multicycle_ctrl_if.master       mem_if,
  output logic                    ir_write,
  output logic                    pc_write,
  output logic [1:0]              pc_sel,
  output logic                    reg_write,
  output logic                    wb_sel,
  output logic                    base_write,
  output logic [2:0]              alu_op,
  output logic                    alu_src_imm,
  output logic                    ext_signed,
  output logic                    sp_write,
  output logic                    sp_dec,
  output logic                    illegal,
  output logic [2:0]              state_o
);

  localparam int unsigned WD_W = $clog2(MEM_TO);

  // Opcode encodings
  localparam logic [5:0] OP_AND  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_ANDI = 6'h03;
  localparam logic [5:0] OP_ADDI = 6'h04;
  localparam logic [5:0] OP_LW   = 6'h05;
  localparam logic [5:0] OP_SW   = 6'h06;
  localparam logic [5:0] OP_BGT  = 6'h07;
  localparam logic [5:0] OP_BLT  = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h09;
  localparam logic [5:0] OP_BNE  = 6'h0A;
  localparam logic [5:0] OP_JMP  = 6'h0C;
  localparam logic [5:0] OP_CALL = 6'h0D;
  localparam logic [5:0] OP_RET  = 6'h0E;
  localparam logic [5:0] OP_PUSH = 6'h0F;
  localparam logic [5:0] OP_POP  = 6'h10;

  // ALU operation encodings
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_INC = 3'b011;

  // Memory address sources
  localparam logic [1:0] ADDR_PC  = 2'b00;
  localparam logic [1:0] ADDR_ALU = 2'b01;
  localparam logic [1:0] ADDR_SP  = 2'b10;

  // PC next-value sources
  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_ABS  = 2'b10;
  localparam logic [1:0] PC_MEM  = 2'b11;

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_BASE_WB = 3'd6,
    S_TRAP    = 3'd7
  } state_e;

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic              op_legal;
  logic              op_ldst;
  logic              op_load;
  logic              br_taken;
  logic              wd_expired;

  // Opcode classification used by several states
  always_comb begin
    op_legal = 1'b0;
    case (opcode)
      OP_AND, OP_ADD, OP_SUB, OP_ANDI, OP_ADDI, OP_LW, OP_SW,
      OP_BGT, OP_BLT, OP_BEQ, OP_BNE, OP_JMP, OP_CALL, OP_RET,
      OP_PUSH, OP_POP: op_legal = 1'b1;
      default:         op_legal = 1'b0;
    endcase
    op_ldst = (opcode == OP_LW) || (opcode == OP_SW);
    op_load = (opcode == OP_LW) || (opcode == OP_POP);
  end

  // Branch condition from live ALU flags of rd - rs1
  always_comb begin
    br_taken = 1'b0;
    case (opcode)
      OP_BEQ:  br_taken = flag_z;
      OP_BNE:  br_taken = !flag_z;
      OP_BGT:  br_taken = !flag_z && !flag_n;
      OP_BLT:  br_taken = flag_n;
      default: br_taken = 1'b0;
    endcase
  end

  // Last permitted wait cycle: no ack now means timeout
  assign wd_expired = (wd_cnt_q == WD_W'(MEM_TO - 1));

  // State and watchdog registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INIT;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_d         = state_q;
    mem_if.mem_req  = 1'b0;
    mem_if.mem_we   = 1'b0;
    mem_if.addr_sel = ADDR_PC;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_sel          = PC_INC;
    reg_write       = 1'b0;
    wb_sel          = 1'b0;
    base_write      = 1'b0;
    alu_op          = ALU_AND;
    alu_src_imm     = 1'b0;
    ext_signed      = 1'b0;
    sp_write        = 1'b0;
    sp_dec          = 1'b0;
    illegal         = 1'b0;

    case (state_q)
      S_INIT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        mem_if.mem_req  = 1'b1;
        mem_if.addr_sel = ADDR_PC;
        if (mem_if.mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_sel   = PC_INC;
          state_d  = S_DECODE;
        end else if (wd_expired) begin
          state_d = S_TRAP;
        end
      end

      S_DECODE: begin
        if (!op_legal || (op_ldst && mode[1])) begin
          state_d = S_TRAP;
        end else begin
          case (opcode)
            OP_JMP: begin
              pc_write = 1'b1;
              pc_sel   = PC_ABS;
              state_d  = S_FETCH;
            end
            OP_CALL, OP_PUSH: begin
              state_d = S_MEM;
            end
            OP_RET, OP_POP: begin
              // Pre-increment SP so the pop reads the top-of-stack slot
              sp_write = 1'b1;
              sp_dec   = 1'b0;
              state_d  = S_MEM;
            end
            default: begin
              state_d = S_EXEC;
            end
          endcase
        end
      end

      S_EXEC: begin
        case (opcode)
          OP_AND, OP_ADD, OP_SUB: begin
            alu_op  = opcode[2:0];
            state_d = S_WB;
          end
          OP_ANDI: begin
            alu_op      = ALU_AND;
            alu_src_imm = 1'b1;
            ext_signed  = 1'b0;
            state_d     = S_WB;
          end
          OP_ADDI: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            ext_signed  = 1'b1;
            state_d     = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_op      = ALU_ADD;
            alu_src_imm = 1'b1;
            ext_signed  = 1'b1;
            state_d     = S_MEM;
          end
          OP_BGT, OP_BLT, OP_BEQ, OP_BNE: begin
            alu_op   = ALU_SUB;
            pc_sel   = PC_REL;
            pc_write = br_taken;
            state_d  = S_FETCH;
          end
          default: begin
            // Unreachable: DECODE only forwards the opcodes above
            state_d = S_TRAP;
          end
        endcase
      end

      S_MEM: begin
        mem_if.mem_req  = 1'b1;
        mem_if.addr_sel = op_ldst ? ADDR_ALU : ADDR_SP;
        mem_if.mem_we   = (opcode == OP_SW) || (opcode == OP_PUSH) ||
                          (opcode == OP_CALL);
        if (mem_if.mem_ack) begin
          case (opcode)
            OP_LW, OP_POP: begin
              state_d = S_WB;
            end
            OP_SW: begin
              state_d = (mode == 2'b01) ? S_BASE_WB : S_FETCH;
            end
            OP_PUSH: begin
              sp_write = 1'b1;
              sp_dec   = 1'b1;
              state_d  = S_FETCH;
            end
            OP_CALL: begin
              sp_write = 1'b1;
              sp_dec   = 1'b1;
              pc_write = 1'b1;
              pc_sel   = PC_ABS;
              state_d  = S_FETCH;
            end
            OP_RET: begin
              pc_write = 1'b1;
              pc_sel   = PC_MEM;
              state_d  = S_FETCH;
            end
            default: begin
              state_d = S_TRAP;
            end
          endcase
        end else if (wd_expired) begin
          state_d = S_TRAP;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = op_load;
        state_d   = ((opcode == OP_LW) && (mode == 2'b01)) ? S_BASE_WB : S_FETCH;
      end

      S_BASE_WB: begin
        base_write = 1'b1;
        alu_op     = ALU_INC;
        state_d    = S_FETCH;
      end

      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

  // Watchdog counts wait cycles; any state change into FETCH/MEM restarts it
  always_comb begin
    wd_cnt_d = '0;
    if (((state_q == S_FETCH) || (state_q == S_MEM)) && (state_d == state_q)) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [1:0] mode;
  logic       flag_z, flag_n;
  logic       ir_write, pc_write, reg_write, wb_sel, base_write;
  logic       alu_src_imm, ext_signed, sp_write, sp_dec, illegal;
  logic [1:0] pc_sel;
  logic [2:0] alu_op, state_o;

  int n_checks = 0;
  int n_errors = 0;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.MEM_TO(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mode        (mode),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .mem_if      (mem_if),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .base_write  (base_write),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .ext_signed  (ext_signed),
    .sp_write    (sp_write),
    .sp_dec      (sp_dec),
    .illegal     (illegal),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point lands 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present the instruction with ack, end up in DECODE
  task automatic fetch(input logic [5:0] op, input logic [1:0] md);
    opcode = op;
    mode   = md;
    mem_if.mem_ack = 1'b1;
    #1;
    check_eq("fetch_irw", ir_write, 1);
    step();
    mem_if.mem_ack = 1'b0;
    #1;
    check_eq("fetch_to_dec", state_o, 2);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    check_eq("rst_init", state_o, 0);
    step();
    check_eq("init_to_fetch", state_o, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    opcode = 6'h00;
    mode = 2'b00;
    flag_z = 1'b0;
    flag_n = 1'b0;
    mem_if.mem_ack = 1'b0;
    #2;
    check_eq("rst_state", state_o, 0);
    check_eq("rst_req", mem_if.mem_req, 0);
    check_eq("rst_ill", illegal, 0);
    do_reset();

    // ADD with ack one cycle late
    opcode = 6'h01;
    check_eq("add_f_req", mem_if.mem_req, 1);
    check_eq("add_f_addr", mem_if.addr_sel, 0);
    check_eq("add_f_regw", reg_write, 0);
    step();
    check_eq("add_f_wait", state_o, 1);
    fetch(6'h01, 2'b00);
    check_eq("add_d_regw", reg_write, 0);
    step();
    check_eq("add_exec", state_o, 3);
    check_eq("add_aluop", alu_op, 3'b001);
    check_eq("add_e_regw", reg_write, 0);
    step();
    check_eq("add_wb", state_o, 5);
    check_eq("add_wb_regw", reg_write, 1);
    check_eq("add_wb_sel", wb_sel, 0);
    step();
    check_eq("add_done", state_o, 1);

    // BEQ taken and not taken, BLT taken, BGT not taken on negative
    for (int i = 0; i < 4; i++) begin
      logic [5:0] op;
      logic z, n, exp_pw;
      case (i)
        0: begin op = 6'h09; z = 1'b1; n = 1'b0; exp_pw = 1'b1; end
        1: begin op = 6'h09; z = 1'b0; n = 1'b0; exp_pw = 1'b0; end
        2: begin op = 6'h08; z = 1'b0; n = 1'b1; exp_pw = 1'b1; end
        default: begin op = 6'h07; z = 1'b0; n = 1'b1; exp_pw = 1'b0; end
      endcase
      fetch(op, 2'b00);
      step();
      check_eq("br_exec", state_o, 3);
      flag_z = z;
      flag_n = n;
      #1;
      check_eq($sformatf("br%0d_pcw", i), pc_write, 32'(exp_pw));
      check_eq($sformatf("br%0d_pcsel", i), pc_sel, 2'b01);
      check_eq($sformatf("br%0d_alu", i), alu_op, 3'b010);
      step();
      check_eq($sformatf("br%0d_next", i), state_o, 1);
      flag_z = 1'b0;
      flag_n = 1'b0;
    end

    // LW with base update
    fetch(6'h05, 2'b01);
    step();
    check_eq("lw_exec_ext", ext_signed, 1);
    check_eq("lw_exec_imm", alu_src_imm, 1);
    step();
    check_eq("lw_mem", state_o, 4);
    check_eq("lw_mem_addr", mem_if.addr_sel, 2'b01);
    check_eq("lw_mem_we", mem_if.mem_we, 0);
    check_eq("lw_mem_req", mem_if.mem_req, 1);
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    #1;
    check_eq("lw_wb", state_o, 5);
    check_eq("lw_wb_sel", wb_sel, 1);
    step();
    check_eq("lw_bwb", state_o, 6);
    check_eq("lw_bwb_w", base_write, 1);
    check_eq("lw_bwb_alu", alu_op, 3'b011);
    step();
    check_eq("lw_done", state_o, 1);

    // CALL
    fetch(6'h0D, 2'b00);
    step();
    check_eq("call_mem", state_o, 4);
    check_eq("call_we", mem_if.mem_we, 1);
    check_eq("call_addr", mem_if.addr_sel, 2'b10);
    mem_if.mem_ack = 1'b1;
    #1;
    check_eq("call_spw", sp_write, 1);
    check_eq("call_spdec", sp_dec, 1);
    check_eq("call_pcsel", pc_sel, 2'b10);
    check_eq("call_pcw", pc_write, 1);
    step();
    mem_if.mem_ack = 1'b0;
    check_eq("call_done", state_o, 1);

    // RET
    fetch(6'h0E, 2'b00);
    check_eq("ret_d_spw", sp_write, 1);
    check_eq("ret_d_spdec", sp_dec, 0);
    step();
    check_eq("ret_we", mem_if.mem_we, 0);
    mem_if.mem_ack = 1'b1;
    #1;
    check_eq("ret_pcsel", pc_sel, 2'b11);
    check_eq("ret_pcw", pc_write, 1);
    step();
    mem_if.mem_ack = 1'b0;
    check_eq("ret_done", state_o, 1);

    // SW: ack arriving on the 16th MEM cycle is honoured
    fetch(6'h06, 2'b00);
    step();
    step();
    check_eq("sw_mem", state_o, 4);
    repeat (15) step();
    check_eq("sw_mem16", state_o, 4);
    mem_if.mem_ack = 1'b1;
    step();
    mem_if.mem_ack = 1'b0;
    check_eq("sw_ack16", state_o, 1);

    // PUSH: no ack for 16 MEM cycles traps
    fetch(6'h0F, 2'b00);
    step();
    check_eq("push_mem", state_o, 4);
    repeat (15) step();
    check_eq("push_mem16", state_o, 4);
    step();
    check_eq("push_to", state_o, 7);
    check_eq("push_to_ill", illegal, 1);
    check_eq("push_to_req", mem_if.mem_req, 0);

    // Asynchronous reset during a MEM wait
    do_reset();
    fetch(6'h06, 2'b00);
    step();
    step();
    step();
    check_eq("ar_mem", state_o, 4);
    rst_n = 1'b0;
    #1;
    check_eq("ar_req", mem_if.mem_req, 0);
    check_eq("ar_state", state_o, 0);
    step();
    rst_n = 1'b1;
    #1;
    check_eq("ar_init", state_o, 0);
    step();
    check_eq("ar_fetch", state_o, 1);

    // Illegal opcode traps and stays there
    fetch(6'h3F, 2'b00);
    step();
    check_eq("ill_trap", state_o, 7);
    check_eq("ill_flag", illegal, 1);
    mem_if.mem_ack = 1'b1;
    repeat (3) step();
    mem_if.mem_ack = 1'b0;
    check_eq("ill_sticky", illegal, 1);
    check_eq("ill_hold", state_o, 7);
    check_eq("ill_req", mem_if.mem_req, 0);

    // LW with reserved mode traps from DECODE
    do_reset();
    fetch(6'h05, 2'b10);
    step();
    check_eq("lwm_trap", state_o, 7);
    check_eq("lwm_ill", illegal, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
